multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle control unit. A registered FSM sequences each RISC-V instruction through fetch, decode, execute, memory and writeback states, and drives datapath enables one state at a time. It waits on a shared instruction/data memory through a ready handshake, and has a parametrised ALUOp width and a memory-wait watchdog. It sits between the instruction register and the shared-memory datapath.

---
 rtl/mc_ctrl_pkg.sv | 17 +
 rtl/mc_ctrl_decoder.sv | 14 +
 rtl/multicycle_control_unit.sv | 115 +++++++++++
 tb/tb_multicycle_control_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state/class enums, opcode constants and ALU/operand codes for the multicycle control unit.
package mc_ctrl_pkg;
  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK, ST_ERROR} state_e;
  typedef enum logic [2:0] {CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH} cls_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_IMM = 3'b110;
  localparam logic [2:0] ALU_R   = 3'b111;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
endpackage

// File: rtl/mc_ctrl_decoder.sv
// mc_ctrl_decoder: combinational opcode-to-class decode; unlisted opcodes map to R and raise illegal.
module mc_ctrl_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls,
  output logic       illegal
);
  assign cls = opcode == OP_IALU   ? CLS_IALU :
               opcode == OP_LOAD   ? CLS_LOAD :
               opcode == OP_STORE  ? CLS_STORE :
               opcode == OP_BRANCH ? CLS_BRANCH : CLS_R;
  assign illegal = !(opcode inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH});
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with memory-wait watchdog.
// Define CTRL_ILLEGAL_TRAP_EN to trap unlisted opcodes into ERROR instead of executing them as R.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W        = 3,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               mem_to_reg,
  output logic               branch,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               bus_error,
  output logic               illegal_instr
);
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  state_e        state_q, state_d;
  cls_e          cls_q, cls_d, dec_cls;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d, ill_q, ill_d, dec_ill, waiting, timeout;
  mc_ctrl_decoder u_dec (.opcode(opcode), .cls(dec_cls), .illegal(dec_ill));
  assign waiting = (state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready;
  assign timeout = TIMEOUT_CYCLES != 0 && waiting && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign cnt_d = (waiting && state_d == state_q) ? cnt_q + CW'(1) : '0;
  assign bus_err_d = bus_err_q || (timeout && state_d == ST_ERROR);
  assign ill_d = ill_q || (state_q == ST_DECODE && TRAP_EN && dec_ill);
  assign bus_error = bus_err_q;
  assign illegal_instr = TRAP_EN && ill_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_R;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      ill_q     <= ill_d;
    end
  end
  // Outputs are forced low while reset_n is asserted so an aborted instruction cannot glitch an enable.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    alu_op     = '0;
    instr_done = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
          state_d   = mem_ready ? ST_DECODE : timeout ? ST_ERROR : ST_FETCH;
        end
        ST_DECODE: begin
          cls_d   = dec_cls;
          state_d = TRAP_EN && dec_ill ? ST_ERROR : ST_EXECUTE;
        end
        ST_EXECUTE: begin
          alu_src_a   = 1'b1;
          alu_src_b   = cls_q inside {CLS_R, CLS_BRANCH} ? SRCB_RS2 : SRCB_IMM;
          alu_op[2:0] = cls_q == CLS_R ? ALU_R : cls_q == CLS_IALU ? ALU_IMM :
                        cls_q == CLS_BRANCH ? ALU_SUB : ALU_ADD;
          branch      = cls_q == CLS_BRANCH;
          instr_done  = cls_q == CLS_BRANCH;
          state_d     = cls_q == CLS_BRANCH ? ST_FETCH :
                        cls_q inside {CLS_LOAD, CLS_STORE} ? ST_MEM : ST_WRITEBACK;
        end
        ST_MEM: begin
          mem_read   = cls_q == CLS_LOAD;
          mem_write  = cls_q != CLS_LOAD;
          instr_done = cls_q != CLS_LOAD && mem_ready;
          state_d    = mem_ready ? (cls_q == CLS_LOAD ? ST_WRITEBACK : ST_FETCH) :
                       timeout ? ST_ERROR : ST_MEM;
        end
        ST_WRITEBACK: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          mem_to_reg = cls_q == CLS_LOAD;
          state_d    = ST_FETCH;
        end
        default: state_d = ST_ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed checks of sequencing, memory waits, watchdog, reset abort and illegal opcodes.
module tb_multicycle_control_unit;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic       mem_ready = 1'b1;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, alu_src_a, mem_to_reg, branch, instr_done;
  logic       bus_error, illegal_instr;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  int         n_assert = 0;
  int         n_fail = 0;
  logic [13:0] exp_ex, exp_wb;
  logic        exp_ill;
  always #5 clk = ~clk;
  multicycle_control_unit dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg),
    .branch(branch), .alu_op(alu_op), .instr_done(instr_done), .bus_error(bus_error),
    .illegal_instr(illegal_instr)
  );
  function automatic logic [13:0] e(input logic pw, iw, rw, mr, mw, sa, input logic [1:0] sb,
                                    input logic mtr, br, input logic [2:0] op, input logic done);
    return {pw, iw, rw, mr, mw, sa, sb, mtr, br, op, done};
  endfunction
  localparam logic [13:0] NONE   = 14'd0;
  localparam logic [13:0] F_WAIT = {5'b00010, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0};
  localparam logic [13:0] F_GO   = {5'b11010, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0};
  localparam logic [13:0] EX_R   = {5'b00000, 1'b1, 2'b00, 2'b00, 3'b111, 1'b0};
  localparam logic [13:0] EX_I   = {5'b00000, 1'b1, 2'b10, 2'b00, 3'b110, 1'b0};
  localparam logic [13:0] EX_LS  = {5'b00000, 1'b1, 2'b10, 2'b00, 3'b000, 1'b0};
  localparam logic [13:0] EX_B   = {5'b00000, 1'b1, 2'b00, 2'b01, 3'b001, 1'b1};
  localparam logic [13:0] MEM_L  = {5'b00010, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [13:0] MEM_SW = {5'b00001, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [13:0] MEM_SG = {5'b00001, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1};
  localparam logic [13:0] WB     = {5'b00100, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1};
  localparam logic [13:0] WB_L   = {5'b00100, 1'b0, 2'b00, 2'b10, 3'b000, 1'b1};
  function automatic logic [13:0] obs();
    return e(pc_write, ir_write, reg_write, mem_read, mem_write, alu_src_a, alu_src_b,
             mem_to_reg, branch, alu_op, instr_done);
  endfunction
  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask
  task automatic step(input string tag, input logic mr, input logic [6:0] op, input logic [13:0] want);
    mem_ready = mr;
    opcode = op;
    @(negedge clk);
    chk(tag, obs(), want);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
  initial begin
`ifdef CTRL_ILLEGAL_TRAP_EN
    exp_ex = NONE; exp_wb = NONE; exp_ill = 1'b1;
`else
    exp_ex = EX_R; exp_wb = WB; exp_ill = 1'b0;
`endif
    #2;
    chk("reset_outputs", obs(), NONE);
    chk("reset_flags", {12'd0, bus_error, illegal_instr}, 14'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("r_fetch", 1, 7'b0110011, F_GO);
    step("r_decode", 1, 7'b0110011, NONE);
    step("r_execute", 1, 7'b0000011, EX_R);
    step("r_writeback", 1, 7'b0000011, WB);
    step("i_fetch", 1, 7'b0010011, F_GO);
    step("i_decode", 1, 7'b0010011, NONE);
    step("i_execute", 1, 7'b0010011, EX_I);
    step("i_writeback", 1, 7'b0010011, WB);
    step("ld_fetch", 1, 7'b0000011, F_GO);
    step("ld_decode", 1, 7'b0000011, NONE);
    step("ld_execute", 1, 7'b0000011, EX_LS);
    for (int i = 0; i < 3; i++) step("ld_mem_wait", 0, 7'b0000011, MEM_L);
    step("ld_mem_go", 1, 7'b0000011, MEM_L);
    step("ld_writeback", 1, 7'b0000011, WB_L);
    step("st_fetch_wait", 0, 7'b0100011, F_WAIT);
    step("st_fetch", 1, 7'b0100011, F_GO);
    step("st_decode", 1, 7'b0100011, NONE);
    step("st_execute", 1, 7'b0100011, EX_LS);
    step("st_mem_wait", 0, 7'b0100011, MEM_SW);
    step("st_mem_go", 1, 7'b0100011, MEM_SG);
    step("br_fetch", 1, 7'b1100011, F_GO);
    step("br_decode", 1, 7'b1100011, NONE);
    step("br_execute", 1, 7'b1100011, EX_B);
    step("br_back_to_fetch", 0, 7'b1100011, F_WAIT);
    step("abort_fetch", 1, 7'b0100011, F_GO);
    step("abort_decode", 1, 7'b0100011, NONE);
    step("abort_execute", 1, 7'b0100011, EX_LS);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("abort_mem_before", obs(), MEM_SW);
    reset_n = 1'b0;
    #1;
    chk("abort_mem_in_reset", obs(), NONE);
    @(posedge clk);
    #1;
    chk("abort_held_reset", obs(), NONE);
    reset_n = 1'b1;
    step("abort_refetch", 1, 7'b0100011, F_GO);
    step("ill_decode", 1, 7'b1111111, NONE);
    step("ill_execute", 1, 7'b1111111, exp_ex);
    step("ill_writeback", 1, 7'b1111111, exp_wb);
    chk("ill_flag", {13'd0, illegal_instr}, {13'd0, exp_ill});
    do_reset();
    chk("ill_flag_cleared", {13'd0, illegal_instr}, 14'd0);
    for (int i = 0; i < 14; i++) step("tie_wait", 0, 7'b0110011, F_WAIT);
    step("tie_ready_wins", 1, 7'b0110011, F_GO);
    step("tie_decode", 1, 7'b0110011, NONE);
    chk("tie_no_bus_error", {13'd0, bus_error}, 14'd0);
    step("tie_execute", 1, 7'b0110011, EX_R);
    step("tie_writeback", 1, 7'b0110011, WB);
    for (int i = 0; i < 15; i++) step("wd_wait", 0, 7'b0110011, F_WAIT);
    chk("wd_flag_in_error", {13'd0, bus_error}, 14'd1);
    step("wd_error", 0, 7'b0110011, NONE);
    step("wd_error_ready", 1, 7'b0110011, NONE);
    step("wd_error_hold", 1, 7'b0110011, NONE);
    chk("wd_flag_sticky", {13'd0, bus_error}, 14'd1);
    do_reset();
    chk("wd_flag_cleared", {13'd0, bus_error}, 14'd0);
    step("wd_after_reset", 1, 7'b0110011, F_GO);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
